// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift engine.
// The line idles high, and each frame is a start bit, eight data bits sent LSB first, then a stop bit.
module uart_tx #(
  parameter int BaudRate       = 115200,
  parameter int ClockSpeed_MHz = 100,
  parameter int FifoDepth      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               tx_serial,
  output logic                               tx_busy,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_count
);

  localparam int BAUD_COUNTER_MAX = ClockSpeed_MHz * 1_000_000 / BaudRate;
  localparam int CNT_W = (BAUD_COUNTER_MAX > 1) ? $clog2(BAUD_COUNTER_MAX) : 1;
  localparam int FC_W  = $clog2(FifoDepth + 1);
  localparam int PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNTER_MAX - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FifoDepth];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [FC_W-1:0]  count_q;
  logic             full, empty, push, pop;

  assign full     = (count_q == FC_W'(FifoDepth));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // NOTE: storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + FC_W'(1);
        2'b01:   count_q <= count_q - FC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- Shift engine ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // A queued byte starts its frame straight out of the stop bit, without returning to IDLE.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_serial  = tx_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboarded frame decoding on a default-rate
// instance (MAX=868) and a fast instance (MAX=4).
module tb_uart_tx;

  localparam int M1 = 868;
  localparam int M2 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic       tx_serial, tx2;
  logic       tx_busy, busy2;
  logic [2:0] fifo_count, fc2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];

  uart_tx dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  uart_tx #(.BaudRate(250000), .ClockSpeed_MHz(1), .FifoDepth(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .tx_serial(tx2), .tx_busy(busy2), .fifo_count(fc2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic line(input bit sel);
    return sel ? tx2 : tx_serial;
  endfunction

  function automatic logic busy(input bit sel);
    return sel ? busy2 : tx_busy;
  endfunction

  // Decode one frame starting at the current sample; every cycle of every bit must hold its level.
  task automatic recv_frame(input bit sel, input string tag, input int budget,
                            output int waited, output int start_cyc);
    int m;
    logic [9:0] lvl;
    bit glitch;
    logic [7:0] exp_b;
    m = sel ? M2 : M1;
    waited = 0;
    start_cyc = -1;
    while (line(sel) !== 1'b0 && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    n_tests++;
    if (line(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: line=%b after %0d cycles, required 0", tag, line(sel), waited);
      return;
    end
    start_cyc = cyc;
    glitch = 1'b0;
    lvl = '0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < m; c++) begin
        if (!(b == 0 && c == 0)) begin @(posedge clk); #1; end
        if (c == 0) lvl[b] = line(sel);
        else if (line(sel) !== lvl[b]) glitch = 1'b1;
      end
    end
    n_tests++;
    if (glitch) begin
      n_fail++;
      $display("FAIL %s bit_width: level changed inside a %0d-cycle bit, bits=%b", tag, m, lvl);
    end
    n_tests++;
    if (lvl[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stop_bit: got %b, required 1", tag, lvl[9]);
    end
    exp_b = 8'hxx;
    if (sel && exp2.size() > 0) exp_b = exp2.pop_front();
    if (!sel && exp1.size() > 0) exp_b = exp1.pop_front();
    n_tests++;
    if (lvl[8:1] !== exp_b) begin
      n_fail++;
      $display("FAIL %s data: got %h, required %h", tag, lvl[8:1], exp_b);
    end
  endtask

  task automatic wait_idle(input bit sel, input int budget, output int fall_cyc);
    int n;
    n = 0;
    while (busy(sel) !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    fall_cyc = (busy(sel) === 1'b0) ? cyc : -1;
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] b);
    if (sel) begin in_data2 = b; in_valid2 = 1'b1; end
    else     begin in_data  = b; in_valid  = 1'b1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    if (sel) exp2.push_back(b); else exp1.push_back(b);
  endtask

  task automatic test_reset();
    n_tests += 8;
    if (tx_serial !== 1'b1)  begin n_fail++; $display("FAIL reset tx_serial: got %b, required 1", tx_serial); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset fifo_count: got %0d, required 0", fifo_count); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
    if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset tx_busy: got %b, required 0", tx_busy); end
    if (tx2 !== 1'b1)        begin n_fail++; $display("FAIL reset fast tx_serial: got %b, required 1", tx2); end
    if (fc2 !== 3'd0)        begin n_fail++; $display("FAIL reset fast fifo_count: got %0d, required 0", fc2); end
    if (in_ready2 !== 1'b1)  begin n_fail++; $display("FAIL reset fast in_ready: got %b, required 1", in_ready2); end
    if (busy2 !== 1'b0)      begin n_fail++; $display("FAIL reset fast tx_busy: got %b, required 0", busy2); end
  endtask

  // One byte into an idle transmitter: latency, count handoff, frame content, busy duration.
  task automatic test_one_frame(input bit sel, input string tag, input logic [7:0] b);
    int waited, start_c, fall_c, m;
    m = sel ? M2 : M1;
    push_byte(sel, b);
    n_tests += 2;
    if ((sel ? fc2 : fifo_count) !== 3'd1) begin n_fail++; $display("FAIL %s count_after_push: got %0d, required 1", tag, sel ? fc2 : fifo_count); end
    if (line(sel) !== 1'b1) begin n_fail++; $display("FAIL %s line_at_push: got %b, required 1", tag, line(sel)); end
    @(posedge clk); #1;
    n_tests += 2;
    if (line(sel) !== 1'b0) begin n_fail++; $display("FAIL %s latency: line=%b one cycle after push, required 0", tag, line(sel)); end
    if ((sel ? fc2 : fifo_count) !== 3'd0) begin n_fail++; $display("FAIL %s count_at_start: got %0d, required 0", tag, sel ? fc2 : fifo_count); end
    recv_frame(sel, tag, 4, waited, start_c);
    n_tests++;
    if (busy(sel) !== 1'b1) begin n_fail++; $display("FAIL %s busy_in_stop: got %b, required 1", tag, busy(sel)); end
    wait_idle(sel, 8, fall_c);
    n_tests++;
    if (fall_c - start_c != 10 * m) begin n_fail++; $display("FAIL %s busy_length: got %0d cycles, required %0d", tag, fall_c - start_c, 10 * m); end
  endtask

  task automatic test_back_to_back();
    int w1, w2, w3, s1, s2, s3, fall_c;
    fork
      begin
        in_valid = 1'b1;
        in_data = 8'h00; @(posedge clk); #1; exp1.push_back(8'h00);
        in_data = 8'hFF; @(posedge clk); #1; exp1.push_back(8'hFF);
        in_data = 8'h0F; @(posedge clk); #1; exp1.push_back(8'h0F);
        in_valid = 1'b0;
      end
      begin
        recv_frame(1'b0, "b2b_f1", 4, w1, s1);
        recv_frame(1'b0, "b2b_f2", 4, w2, s2);
        recv_frame(1'b0, "b2b_f3", 4, w3, s3);
      end
    join
    n_tests += 2;
    if (w2 != 1) begin n_fail++; $display("FAIL b2b gap12: start after %0d cycles, required 1", w2); end
    if (w3 != 1) begin n_fail++; $display("FAIL b2b gap23: start after %0d cycles, required 1", w3); end
    wait_idle(1'b0, 8, fall_c);
    n_tests++;
    if (fall_c - s1 != 30 * M1) begin n_fail++; $display("FAIL b2b busy_length: got %0d cycles, required %0d", fall_c - s1, 30 * M1); end
  endtask

  // Valid held for six bytes on the fast instance: FIFO fills, backpressure, in-order drain.
  task automatic test_fill();
    int acc [7];
    int start1, fall_c;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          bit ok;
          int n;
          logic rdy;
          ok = 1'b0;
          n = 0;
          in_data2 = 8'(i);
          in_valid2 = 1'b1;
          while (!ok && n < 200) begin
            rdy = in_ready2;
            @(posedge clk); #1;
            n++;
            ok = rdy;
          end
          n_tests++;
          if (!ok) begin n_fail++; $display("FAIL fill accept_%0d: not accepted in %0d cycles", i, n); end
          else exp2.push_back(8'(i));
          acc[i] = cyc;
          if (i == 5) begin
            n_tests += 2;
            if (fc2 !== 3'd4) begin n_fail++; $display("FAIL fill count_full: got %0d, required 4", fc2); end
            if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL fill ready_full: got %b, required 0", in_ready2); end
          end
        end
        in_valid2 = 1'b0;
      end
      begin
        int w, s;
        recv_frame(1'b1, "fill_f1", 8, w, start1);
        for (int f = 2; f <= 6; f++) recv_frame(1'b1, "fill_fn", 8, w, s);
      end
    join
    n_tests += 2;
    if (start1 - acc[1] != 1) begin n_fail++; $display("FAIL fill first_pop: got %0d cycles, required 1", start1 - acc[1]); end
    if (acc[6] - start1 != 10 * M2 + 1) begin n_fail++; $display("FAIL fill accept6: got %0d cycles after start, required %0d", acc[6] - start1, 10 * M2 + 1); end
    wait_idle(1'b1, 8, fall_c);
    n_tests++;
    if (exp2.size() != 0) begin n_fail++; $display("FAIL fill drained: %0d bytes still expected, required 0", exp2.size()); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    in_valid = 1'b1;
    in_data = 8'h00; @(posedge clk); #1;
    in_data = 8'h00; @(posedge clk); #1;
    in_data = 8'h00; @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2999) begin @(posedge clk); #1; end
    n_tests += 2;
    if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL midreset pre_line: got %b, required 0", tx_serial); end
    if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midreset pre_count: got %0d, required 2", fifo_count); end
    rst_n = 1'b0;
    #1;
    n_tests += 4;
    if (tx_serial !== 1'b1)  begin n_fail++; $display("FAIL midreset line: got %b, required 1", tx_serial); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midreset count: got %0d, required 0", fifo_count); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL midreset ready: got %b, required 1", in_ready); end
    if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL midreset busy: got %b, required 0", tx_busy); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20000) begin
      @(posedge clk); #1;
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL midreset after_release: %0d cycles not idle, required 0", bad); end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_one_frame(1'b0, "single_55", 8'h55);
    test_one_frame(1'b0, "single_a3", 8'hA3);
    test_back_to_back();
    test_one_frame(1'b1, "fast_81", 8'h81);
    test_fill();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
